dmem_imem_arbiter: RTL

DMEM_IMEM_ARBITER -- requirements
Module: dmem_imem_arbiter

---
 rtl/dmem_imem_arbiter.sv | 99 +++++++++
 1 files changed

// File: rtl/dmem_imem_arbiter.sv
// rtl/dmem_imem_arbiter.sv - shares one memory port between instruction fetch and data access
// Data requests win over fetch; each transaction runs IDLE -> BUSY -> RESP -> IDLE.
module dmem_imem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_imem_stall,
    input  logic              m_req,
    input  logic              m_we,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_dmem_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUSY_F,
        S_BUSY_M,
        S_RESP_F,
        S_RESP_M
    } state_t;

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_f_rdata;
    logic [DATA_W-1:0]   r_m_rdata;
    logic                w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_f_rdata <= '0;
            r_m_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m_req) begin
                        r_state <= S_BUSY_M;
                        r_we    <= m_we;
                        r_addr  <= m_addr;
                        r_wdata <= m_wdata;
                    end else if (f_req) begin
                        r_state <= S_BUSY_F;
                        r_we    <= 1'b0;
                        r_addr  <= f_addr;
                        r_wdata <= '0;
                    end
                end
                // A flushed fetch still runs to completion; the pipeline drops the word.
                S_BUSY_F: begin
                    if (mem_ack) begin
                        r_state   <= S_RESP_F;
                        r_f_rdata <= mem_rdata;
                    end
                end
                S_BUSY_M: begin
                    if (mem_ack) begin
                        r_state <= S_RESP_M;
                        if (!r_we) begin
                            r_m_rdata <= mem_rdata;
                        end
                    end
                end
                S_RESP_F: r_state <= S_IDLE;
                S_RESP_M: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Stalls come only from registered state and request levels, never from mem_ack.
    assign w_busy       = (r_state == S_BUSY_F) || (r_state == S_BUSY_M);
    assign mem_req      = w_busy;
    assign mem_we       = w_busy & r_we;
    assign mem_addr     = r_addr;
    assign mem_wdata    = r_wdata;
    assign f_rdata      = r_f_rdata;
    assign m_rdata      = r_m_rdata;
    assign f_imem_stall = f_req & (r_state != S_RESP_F);
    assign m_dmem_stall = m_req & (r_state != S_RESP_M);

endmodule
